// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared types and widths for the memory command front-end.
//   ADDR_W / DATA_W match the 16x32 single-port memory downstream.
//   state_t    : controller FSM states
//   mem_cmd_t  : one queued host command (write flag, address, write data)
package mem_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    RSP     = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
//   In-order command queue between the host handshake and the issue FSM.
//   Head entry is visible combinationally; pop consumes it at the clock edge.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset (empties queue)
//     push, push_data   write one command (ignored when full)
//     pop, head         consume / observe the oldest command (ignored when empty)
//     full, empty       occupancy flags, valid before the edge
module cmd_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  mem_cmd_t push_data,
  input  logic     pop,
  output mem_cmd_t head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  mem_cmd_t         slots [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign head = slots[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_cmd_ctrl.sv
// mem_cmd_ctrl
//   Command front-end for the 16x32 single-port memory. Host commands are
//   queued in cmd_fifo and issued one at a time on registered mem_en/mem_re
//   pins. A read waits for the memory's one-cycle valid pulse (or a timeout)
//   and holds the result on rsp_* until the host takes it.
//   Widths come from mem_ctrl_pkg (ADDR_W=4, DATA_W=32).
//   Ports:
//     clk, rst                       clock, asynchronous active-low reset
//     cmd_valid/ready/write/addr/wdata  host command handshake
//     rsp_valid/ready/rdata/err      held read response (err = timed out)
//     mem_en/re/addr/wdata           registered memory command pins
//     mem_rdata, mem_valid           memory read data and its valid pulse
//     busy                           queue non-empty, FSM active or issue pending
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | pop queue head; writes issue and stay, reads issue and leave
//   WAIT_RD | read issued, waiting for mem_valid or the timeout to expire
//   RSP     | response held on rsp_* until rsp_ready
module mem_cmd_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Down-counter: loaded on read issue, timeout fires when it is already
  // zero, i.e. after TIMEOUT full cycles spent in WAIT_RD.
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              ready_q;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [CNT_W-1:0]  tmo_cnt_nxt;

  mem_cmd_t          push_cmd;
  mem_cmd_t          head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  logic              mem_en_nxt;
  logic              mem_re_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              rsp_err_nxt;

  // cmd_ready stays low through reset and rises on the first edge after it.
  assign cmd_ready = ready_q && !full;
  assign push      = cmd_valid && cmd_ready;
  assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign busy = !empty || (state != IDLE) || mem_en || mem_re;

  always_comb begin
    state_nxt     = state;
    tmo_cnt_nxt   = tmo_cnt;
    pop           = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_re_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;

    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          mem_addr_nxt = head.addr;
          if (head.write) begin
            mem_en_nxt    = 1'b1;
            mem_wdata_nxt = head.wdata;
          end else begin
            mem_re_nxt  = 1'b1;
            tmo_cnt_nxt = TMO_LOAD;
            state_nxt   = WAIT_RD;
          end
        end
      end

      WAIT_RD: begin
        // A data pulse wins over a timeout landing on the same edge.
        if (mem_valid) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = mem_rdata;
          rsp_err_nxt   = 1'b0;
          state_nxt     = RSP;
        end else if (tmo_cnt == '0) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          state_nxt     = RSP;
        end else begin
          tmo_cnt_nxt = tmo_cnt - CNT_W'(1);
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      tmo_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ready_q   <= 1'b1;
      tmo_cnt   <= tmo_cnt_nxt;
      mem_en    <= mem_en_nxt;
      mem_re    <= mem_re_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// tb_mem_cmd_ctrl
//   Drives mem_cmd_ctrl against a behavioural 16x32 memory and compares every
//   cycle with a transaction-level reference (command queue + issue timing).
module tb_mem_cmd_ctrl;

  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_addr = 4'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_re;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_cmd_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .busy      (busy)
  );

  // ---------------- behavioural memory (not reset with the controller) ----
  logic [31:0] mem_arr [16] = '{default: 32'h0};
  logic        mv_q = 1'b0;
  logic [31:0] md_q = 32'h0;
  logic        drop_mode = 1'b0;
  logic        stray = 1'b0;

  always @(posedge clk) begin
    if (mem_en) mem_arr[mem_addr] <= mem_wdata;
    mv_q <= mem_re && !drop_mode;
    if (mem_re) md_q <= mem_arr[mem_addr];
  end
  assign mem_valid = mv_q | stray;
  assign mem_rdata = md_q;

  // ---------------- reference model --------------------------------------
  typedef struct packed {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
  } hcmd_t;

  hcmd_t       q[$];
  logic [31:0] shadow [16] = '{default: 32'h0};
  bit          m_ready_ok = 0;
  bit          m_en = 0, m_re = 0, m_rv = 0, m_err = 0, m_out = 0;
  logic [3:0]  m_addr = 4'h0;
  logic [31:0] m_wdata = 32'h0, m_rdata = 32'h0;
  int          m_rsp_edge = 0;
  logic [31:0] m_rsp_data = 32'h0;
  bit          m_rsp_err = 0;
  int          cyc = 0;

  always @(posedge clk or negedge rst) begin : model
    bit    push_e;
    bit    pop_e;
    hcmd_t h;
    if (!rst) begin
      q.delete();
      m_ready_ok = 0;
      m_en = 0; m_re = 0; m_rv = 0; m_err = 0; m_out = 0;
      m_addr = 4'h0; m_wdata = 32'h0; m_rdata = 32'h0;
    end else begin
      cyc++;
      if (m_en) shadow[m_addr] = m_wdata;
      push_e = cmd_valid && m_ready_ok && (q.size() < DEPTH);
      pop_e  = !m_out && (q.size() > 0);
      if (m_rv && rsp_ready) begin
        m_rv  = 0;
        m_out = 0;
      end else if (m_out && !m_rv && cyc == m_rsp_edge) begin
        m_rv    = 1;
        m_rdata = m_rsp_data;
        m_err   = m_rsp_err;
      end
      m_en = 0;
      m_re = 0;
      if (pop_e) begin
        h = q.pop_front();
        m_addr = h.a;
        if (h.w) begin
          m_en    = 1;
          m_wdata = h.d;
        end else begin
          m_re       = 1;
          m_out      = 1;
          m_rsp_err  = drop_mode;
          m_rsp_edge = cyc + (drop_mode ? TIMEOUT : 2);
          m_rsp_data = drop_mode ? 32'h0 : shadow[h.a];
        end
      end
      if (push_e) q.push_back('{w: cmd_write, a: cmd_addr, d: cmd_wdata});
      m_ready_ok = 1;
    end
  end

  function automatic bit m_idle();
    return (q.size() == 0) && !m_out && !m_en && !m_re;
  endfunction

  // ---------------- checking ---------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready_ok && (q.size() < DEPTH)));
    chk("mem_en", 32'(mem_en), 32'(m_en));
    chk("mem_re", 32'(mem_re), 32'(m_re));
    if (m_en || m_re) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (m_en) chk("mem_wdata", mem_wdata, m_wdata);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    if (m_rv) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    chk("busy", 32'(busy), 32'((q.size() > 0) || m_out || m_en || m_re));
  end

  // Issue/response traces for the hand-computed expectations.
  int          en_cyc[$];
  logic [3:0]  en_addr[$];
  logic [31:0] en_wdata[$];
  logic [3:0]  re_addr[$];
  logic [31:0] rsp_log[$];

  always @(negedge clk) begin
    if (mem_en) begin
      en_cyc.push_back(cyc);
      en_addr.push_back(mem_addr);
      en_wdata.push_back(mem_wdata);
    end
    if (mem_re) re_addr.push_back(mem_addr);
  end

  always @(posedge clk) begin
    if (rst && rsp_valid && rsp_ready) rsp_log.push_back(rsp_rdata);
  end

  task automatic clear_logs();
    en_cyc.delete();
    en_addr.delete();
    en_wdata.delete();
    re_addr.delete();
    rsp_log.delete();
  endtask

  // ---------------- stimulus helpers (enter and leave at negedge+1) -------
  task automatic send(input bit w, input logic [3:0] a, input logic [31:0] d, output int acc);
    bit rdy;
    acc = -1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int n = 0; n < 100; n++) begin
      rdy = cmd_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        acc = cyc;
        break;
      end
      #1;
    end
    #1;
    cmd_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL send: command not accepted within 100 cycles");
    end
  endtask

  task automatic wait_rsp(input int acc, input int exp_lat, input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(cyc - acc), 32'(exp_lat));
  endtask

  task automatic wait_idle();
    int n;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    stray     = 1'b0;
    n = 0;
    while ((!m_idle() || busy) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!m_idle() || busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: busy=%0d still set after %0d cycles", busy, n);
    end
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      cmd_valid = ($urandom_range(0, 99) < 60);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cmd_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 99) < 50);
      // Stray pulses only while the controller cannot be in WAIT_RD.
      stray     = !m_out && ($urandom_range(0, 99) < 10);
    end
    @(negedge clk); #1;
    stray     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------------------------------
  initial begin : main
    int a0;
    int a1;
    int i;
    logic [31:0] exp_drain [6];
    exp_drain = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h1, 32'h2};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    #1 rst = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
    #1;

    // Write then read the same address.
    clear_logs();
    send(1'b1, 4'h5, 32'hDEADBEEF, a0);
    send(1'b0, 4'h5, 32'h0, a1);
    wait_rsp(a1, 3, "rd5");
    chk("rd5_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd5_err", 32'(rsp_err), 32'h0);
    #1;
    wait_idle();
    chk("wr5_count", 32'(en_addr.size()), 32'd1);
    chk("wr5_addr", 32'(en_addr[0]), 32'h5);
    chk("wr5_wdata", en_wdata[0], 32'hDEADBEEF);

    // Four back-to-back writes.
    clear_logs();
    for (i = 0; i < 4; i++) send(1'b1, 4'(i), 32'(i + 1), a0);
    wait_idle();
    chk("bb_count", 32'(en_cyc.size()), 32'd4);
    chk("bb_re_count", 32'(re_addr.size()), 32'd0);
    for (i = 0; i < en_cyc.size() && i < 4; i++) begin
      chk("bb_addr", 32'(en_addr[i]), 32'(i));
      if (i > 0) chk("bb_consecutive", 32'(en_cyc[i] - en_cyc[i-1]), 32'd1);
    end

    // Six reads with the response held: queue fills, then drains in order.
    clear_logs();
    rsp_ready = 1'b0;
    for (i = 0; i < 5; i++) send(1'b0, 4'(i % 4), 32'h0, a0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'h1;
    chk("full_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("full_rsp_held", 32'(rsp_valid), 32'h1);
    chk("full_rsp_data", rsp_rdata, 32'h1);
    rsp_ready = 1'b1;
    send(1'b0, 4'h1, 32'h0, a0);
    wait_idle();
    chk("drain_count", 32'(rsp_log.size()), 32'd6);
    for (i = 0; i < rsp_log.size() && i < 6; i++) chk("drain_data", rsp_log[i], exp_drain[i]);

    // Memory never answers: timeout response.
    drop_mode = 1'b1;
    send(1'b0, 4'h2, 32'h0, a0);
    wait_rsp(a0, 1 + TIMEOUT, "tmo");
    chk("tmo_rdata", rsp_rdata, 32'h0);
    chk("tmo_err", 32'(rsp_err), 32'h1);
    #1;
    wait_idle();
    drop_mode = 1'b0;

    // Highest address.
    clear_logs();
    send(1'b1, 4'hF, 32'h0000_0001, a0);
    send(1'b0, 4'hF, 32'h0, a1);
    wait_rsp(a1, 3, "rdF");
    chk("rdF_rdata", rsp_rdata, 32'h1);
    #1;
    wait_idle();
    chk("wrF_addr", 32'(en_addr.size() > 0 ? en_addr[0] : 4'h0), 32'hF);
    chk("rdF_addr", 32'(re_addr.size() > 0 ? re_addr[0] : 4'h0), 32'hF);

    // Reset while waiting for read data.
    send(1'b0, 4'h1, 32'h0, a0);
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("mid_rst_mem_re", 32'(mem_re), 32'h0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'h0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    stray = 1'b1;
    @(negedge clk); #1;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    #1;

    // Randomized traffic, including a stretch where the memory stays silent.
    random_phase(800);
    wait_idle();
    drop_mode = 1'b1;
    random_phase(300);
    wait_idle();
    drop_mode = 1'b0;
    random_phase(800);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
